// File: rtl/dm_stage_pkg.sv
// Shared definitions for the memory-access stage:
// memory op codes, exception codes and the timer register map.
package dm_stage_pkg;

   typedef enum logic [3:0] {
      MOP_NONE = 4'd0,
      MOP_LW   = 4'd1,
      MOP_LH   = 4'd2,
      MOP_LHU  = 4'd3,
      MOP_LB   = 4'd4,
      MOP_LBU  = 4'd5,
      MOP_SW   = 4'd8,
      MOP_SH   = 4'd9,
      MOP_SB   = 4'd10
   } mem_op_e;

   typedef enum logic [4:0] {
      EXC_NONE = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5
   } exc_e;

   localparam logic [31:0] TC0_BASE     = 32'h0000_7F00;
   localparam logic [31:0] TC1_BASE     = 32'h0000_7F10;
   localparam logic [31:0] TC_SPAN      = 32'd12;
   localparam logic [1:0]  TC_COUNT_WRD = 2'd2;

   function automatic logic op_is_load(input logic [3:0] op);
      return op == MOP_LW || op == MOP_LH || op == MOP_LHU ||
             op == MOP_LB || op == MOP_LBU;
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      return op == MOP_SW || op == MOP_SH || op == MOP_SB;
   endfunction

endpackage

// File: rtl/dm_stage_if.sv
// EX/MEM-side and bridge-side signals of the memory-access stage.
// master drives the request; slave is the stage itself.
interface dm_stage_if;

   logic        req;
   logic [3:0]  mem_op;
   logic [31:0] addr;
   logic        addr_ov;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [4:0]  exc_code;
   logic [31:0] dev_addr;
   logic [31:0] dev_wdata;
   logic        dev_we;
   logic [31:0] dev_rdata;

   modport master (
      output req, mem_op, addr, addr_ov, wdata, dev_rdata,
      input  rdata, exc_code, dev_addr, dev_wdata, dev_we
   );

   modport slave (
      input  req, mem_op, addr, addr_ov, wdata, dev_rdata,
      output rdata, exc_code, dev_addr, dev_wdata, dev_we
   );

endinterface

// File: rtl/dm_load_ext.sv
// Picks the addressed half/byte out of a 32-bit word and
// sign- or zero-extends it; non-load ops yield zero.
module dm_load_ext
   import dm_stage_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [3:0]  op_i,
   output logic [31:0] rdata_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   always_comb begin
      byte_s = word_i[8*off_i +: 8];
      half_s = off_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      rdata_o = '0;
      unique case (1'b1)
         (op_i == MOP_LW):  rdata_o = word_i;
         (op_i == MOP_LH):  rdata_o = {{16{half_s[15]}}, half_s};
         (op_i == MOP_LHU): rdata_o = {16'h0, half_s};
         (op_i == MOP_LB):  rdata_o = {{24{byte_s[7]}}, byte_s};
         (op_i == MOP_LBU): rdata_o = {24'h0, byte_s};
         default:           rdata_o = '0;
      endcase
   end

endmodule

// File: rtl/dm_stage.sv
// Memory-access stage: data RAM with byte-lane stores, timer
// bridge routing, load extension and AdEL/AdES detection.
module dm_stage
   import dm_stage_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 3072
)
(
   input logic      clk,
   input logic      reset,
   dm_stage_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

   logic [31:0]   ram_q [DEPTH_WORDS];

   logic          is_ld;
   logic          is_st;
   logic          in_ram;
   logic          in_tc0;
   logic          in_tc1;
   logic          in_tc;
   logic          misal;
   logic          narrow;
   logic          cnt_hit;
   logic [31:0]   tc_off;
   logic          ld_bad;
   logic          st_bad;
   exc_e          exc;
   logic          wr_ok;
   logic          ram_we;
   logic [3:0]    be;
   logic [31:0]   bmask;
   logic [31:0]   wrep;
   logic [AW-1:0] idx;
   logic [31:0]   rd_word;
   logic [31:0]   ld_data;

   always_comb begin
      is_ld  = op_is_load(bus.mem_op);
      is_st  = op_is_store(bus.mem_op);
      in_ram = bus.addr < RAM_BYTES;
      in_tc0 = bus.addr >= TC0_BASE && bus.addr < TC0_BASE + TC_SPAN;
      in_tc1 = bus.addr >= TC1_BASE && bus.addr < TC1_BASE + TC_SPAN;
      in_tc  = in_tc0 | in_tc1;
      tc_off = bus.addr - (in_tc1 ? TC1_BASE : TC0_BASE);
      cnt_hit = in_tc && tc_off[3:2] == TC_COUNT_WRD;
      narrow = bus.mem_op != MOP_LW && bus.mem_op != MOP_SW;
      misal  = 1'b0;
      if (bus.mem_op == MOP_LW || bus.mem_op == MOP_SW)
         misal = bus.addr[1:0] != 2'b00;
      else if (bus.mem_op == MOP_LH || bus.mem_op == MOP_LHU ||
               bus.mem_op == MOP_SH)
         misal = bus.addr[0];
   end

   // Timers only accept whole-word access, and COUNT is read-only.
   always_comb begin
      ld_bad = is_ld & (misal | bus.addr_ov | ~(in_ram | in_tc) |
                        (in_tc & narrow));
      st_bad = is_st & (misal | bus.addr_ov | ~(in_ram | in_tc) |
                        (in_tc & narrow) | cnt_hit);
      exc = EXC_NONE;
      if (ld_bad)
         exc = EXC_ADEL;
      else if (st_bad)
         exc = EXC_ADES;
   end

   always_comb begin
      wr_ok  = is_st & ~st_bad & ~bus.req & ~reset;
      ram_we = wr_ok & in_ram;
      be     = 4'b0000;
      wrep   = '0;
      unique case (1'b1)
         (bus.mem_op == MOP_SW): begin
            be   = 4'b1111;
            wrep = bus.wdata;
         end
         (bus.mem_op == MOP_SH): begin
            be   = 4'b0011 << bus.addr[1:0];
            wrep = {2{bus.wdata[15:0]}};
         end
         (bus.mem_op == MOP_SB): begin
            be   = 4'b0001 << bus.addr[1:0];
            wrep = {4{bus.wdata[7:0]}};
         end
         default: begin
            be   = 4'b0000;
            wrep = '0;
         end
      endcase
      bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      idx   = bus.addr[AW+1:2];
   end

   always_ff @(posedge clk) begin
      if (reset)
         ram_q <= '{default: '0};
      else if (ram_we)
         ram_q[idx] <= (ram_q[idx] & ~bmask) | (wrep & bmask);
   end

   // Reads see the pre-edge contents, so a same-cycle store is not bypassed.
   always_comb begin
      rd_word = in_ram ? ram_q[idx] : bus.dev_rdata;
   end

   dm_load_ext u_ext (
      .word_i  (rd_word),
      .off_i   (bus.addr[1:0]),
      .op_i    (bus.mem_op),
      .rdata_o (ld_data)
   );

   always_comb begin
      bus.rdata     = (exc == EXC_NONE) ? ld_data : '0;
      bus.exc_code  = exc;
      bus.dev_addr  = bus.addr;
      bus.dev_wdata = bus.wdata;
      bus.dev_we    = wr_ok & in_tc;
   end

endmodule
